button_reader: RTL and testbench

Input-side companion to the LED counter: samples raw board push-buttons, synchronises and debounces each one, and presents clean levels plus single-cycle press/release strobes to downstream logic (counters, mode selects). Sits directly behind the board KEY pins, one instance per button bank, in the single `ipClk` domain.

---
 rtl/button_reader.sv | 179 +++++++++++++++++
 tb/tb_button_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_reader.sv
// button_reader: synchronise, debounce and edge-detect a bank of N push-buttons.
// Ports: ipClk / ipReset (asynchronous, active-high); ipButton raw pins (polarity set by
//   ACTIVE_LOW); opButton debounced level (1 = pressed); opPressed / opReleased one-cycle
//   strobes per accepted press / release. All outputs are registered.
// Latency: a level change sampled at edge k is reported after edge k + DEBOUNCE_CYCLES + 2.
// Optional feature macro: BUTTON_REPEAT_EN adds auto-repeat opPressed strobes while a
//   button stays held (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
module button_reader #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic         ipClk,
  input  logic         ipReset,
  input  logic [N-1:0] ipButton,
  output logic [N-1:0] opButton,
  output logic [N-1:0] opPressed,
  output logic [N-1:0] opReleased
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

`ifdef BUTTON_REPEAT_EN
  localparam int            RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW        = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_M1  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_M1 = RW'(REPEAT_PERIOD - 1);
`endif

  // Elaboration-time sanity check on the configuration.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_err
    $error("button_reader: invalid parameter set");
  end

  // Polarity is normalised before the first flop so the synchroniser resets to
  // the not-pressed level (0) regardless of ACTIVE_LOW.
  logic [N-1:0] pin_norm;
  logic [N-1:0] sync1_q, sync2_q;

  assign pin_norm = (ACTIVE_LOW != 0) ? ~ipButton : ipButton;

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_norm;
      sync2_q <= sync1_q;
    end
  end

  genvar g;
  for (g = 0; g < N; g++) begin : g_bit
    logic          sync;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_q, btn_d;
    logic          prs_q, prs_d;
    logic          rel_q, rel_d;
`ifdef BUTTON_REPEAT_EN
    logic [RW-1:0] rpt_q, rpt_d;
    logic          arm_q, arm_d;   // 1 once the first (long) repeat delay has elapsed
`endif

    assign sync = sync2_q[g];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      btn_d   = btn_q;
      prs_d   = 1'b0;
      rel_d   = 1'b0;
`ifdef BUTTON_REPEAT_EN
      rpt_d   = rpt_q;
      arm_d   = arm_q;
`endif
      case (state_q)
        ST_RELEASED: begin
          if (sync) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = CW'(1);
          end
        end
        ST_PRESS_WAIT: begin
          // A drop back to released wins over reaching the count.
          if (!sync) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            btn_d   = 1'b1;
            prs_d   = 1'b1;
`ifdef BUTTON_REPEAT_EN
            rpt_d   = '0;
            arm_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_PRESSED: begin
          if (!sync) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CW'(1);
          end
`ifdef BUTTON_REPEAT_EN
          // Timer only advances in PRESSED; it is frozen during RELEASE_WAIT.
          if (rpt_q == (arm_q ? PERIOD_M1 : DELAY_M1)) begin
            prs_d = 1'b1;
            rpt_d = '0;
            arm_d = 1'b1;
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
`endif
        end
        ST_RELEASE_WAIT: begin
          if (sync) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
            btn_d   = 1'b0;
            rel_d   = 1'b1;
`ifdef BUTTON_REPEAT_EN
            rpt_d   = '0;
            arm_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
        state_q <= ST_RELEASED;
        cnt_q   <= '0;
        btn_q   <= 1'b0;
        prs_q   <= 1'b0;
        rel_q   <= 1'b0;
`ifdef BUTTON_REPEAT_EN
        rpt_q   <= '0;
        arm_q   <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        btn_q   <= btn_d;
        prs_q   <= prs_d;
        rel_q   <= rel_d;
`ifdef BUTTON_REPEAT_EN
        rpt_q   <= rpt_d;
        arm_q   <= arm_d;
`endif
      end
    end

    assign opButton[g]   = btn_q;
    assign opPressed[g]  = prs_q;
    assign opReleased[g] = rel_q;
  end

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: randomized and directed stimulus for button_reader, checked every
// cycle against a behavioural model (run-length of the synchronised level), plus
// directed latency / strobe-vector checks. Works with or without BUTTON_REPEAT_EN.
module tb_button_reader;

  localparam int N    = 4;
  localparam int D    = 8;
  localparam int AL   = 1;
  localparam int RDLY = 40;
  localparam int RPER = 16;
  localparam int LAT  = D + 3;   // ticks from driving a pin to seeing the strobe

  logic         ipClk    = 1'b0;
  logic         ipReset  = 1'b1;
  logic [N-1:0] ipButton = '1;
  logic [N-1:0] opButton, opPressed, opReleased;

  int n_checks = 0;
  int n_errors = 0;

  button_reader #(
    .N(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(AL),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipButton(ipButton),
    .opButton(opButton), .opPressed(opPressed), .opReleased(opReleased)
  );

  always #5 ipClk = ~ipClk;

  // Reference model state
  logic [N-1:0] h0 = '0, h1 = '0;          // pressed-normalised pin samples, last two edges
  logic [N-1:0] m_lvl = '0, m_prs = '0, m_rel = '0;
  int run [N];                            // consecutive edges the seen level differs from m_lvl
  int held[N];                            // edges spent settled-pressed since acceptance
  int dut_prs_cnt[N];
  int dut_rel_cnt[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] seen;
    m_prs = '0;
    m_rel = '0;
    if (ipReset) begin
      h0 = '0; h1 = '0; m_lvl = '0;
      for (int i = 0; i < N; i++) begin run[i] = 0; held[i] = 0; end
      return;
    end
    // The debouncer acts on the pin level sampled two edges earlier.
    seen = h1;
    h1   = h0;
    h0   = (AL != 0) ? ~ipButton : ipButton;
    for (int i = 0; i < N; i++) begin
`ifdef BUTTON_REPEAT_EN
      if (m_lvl[i] && run[i] == 0) begin
        held[i]++;
        if (held[i] == RDLY || (held[i] > RDLY && (held[i] - RDLY) % RPER == 0))
          m_prs[i] = 1'b1;
      end
`endif
      if (seen[i] != m_lvl[i]) begin
        run[i]++;
        if (run[i] == D + 1) begin
          m_lvl[i] = ~m_lvl[i];
          run[i]   = 0;
          held[i]  = 0;
          if (m_lvl[i]) m_prs[i] = 1'b1;
          else          m_rel[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge ipClk);
    model_step();
    @(negedge ipClk);
    chk("level",    opButton,   m_lvl);
    chk("pressed",  opPressed,  m_prs);
    chk("released", opReleased, m_rel);
    chk("overlap",  opPressed & opReleased, '0);
    for (int i = 0; i < N; i++) begin
      if (opPressed[i])  dut_prs_cnt[i]++;
      if (opReleased[i]) dut_rel_cnt[i]++;
    end
  endtask

  task automatic wait_strobe(input logic [N-1:0] mask, input bit rel, input int budget,
                             output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (((rel ? opReleased : opPressed) & mask) != '0) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat, p0, r0, nrep, first, second, tot;
    int hold[N];
    for (int i = 0; i < N; i++) begin
      run[i] = 0; held[i] = 0; dut_prs_cnt[i] = 0; dut_rel_cnt[i] = 0;
    end

    // Reset, then idle with pins released
    repeat (5) tick();
    ipReset = 1'b0;
    repeat (100) tick();
    tot = 0;
    for (int i = 0; i < N; i++) tot += dut_prs_cnt[i] + dut_rel_cnt[i];
    chk("idle_strobes", tot, 0);
    chk("idle_level", opButton, 4'b0000);

    // Single press / release on bit 0
    ipButton[0] = 1'b0;
    wait_strobe(4'b0001, 1'b0, 30, lat);
    chk("b0_press_lat", lat, LAT);
    chk("b0_press_vec", opPressed, 4'b0001);
    chk("b0_press_lvl", opButton, 4'b0001);
    tick();
    chk("b0_press_1cyc", opPressed, 4'b0000);
    repeat (20) tick();
    ipButton[0] = 1'b1;
    wait_strobe(4'b0001, 1'b1, 30, lat);
    chk("b0_rel_lat", lat, LAT);
    chk("b0_rel_vec", opReleased, 4'b0001);
    chk("b0_rel_lvl", opButton, 4'b0000);
    repeat (5) tick();

    // Bit 1: short pulse and bounce train must be rejected
    p0 = dut_prs_cnt[1];
    r0 = dut_rel_cnt[1];
    ipButton[1] = 1'b0; repeat (7) tick();
    ipButton[1] = 1'b1; repeat (3) tick();
    for (int b = 0; b < 5; b++) begin
      ipButton[1] = 1'b0; repeat (3) tick();
      ipButton[1] = 1'b1; repeat (2) tick();
    end
    repeat (15) tick();
    chk("b1_glitch_prs", dut_prs_cnt[1] - p0, 0);
    chk("b1_glitch_rel", dut_rel_cnt[1] - r0, 0);
    chk("b1_glitch_lvl", opButton, 4'b0000);
    ipButton[1] = 1'b0;
    wait_strobe(4'b0010, 1'b0, 30, lat);
    chk("b1_steady_lat", lat, LAT);
    ipButton[1] = 1'b1;
    wait_strobe(4'b0010, 1'b1, 30, lat);
    repeat (5) tick();

    // Bits 2 and 3 together
    ipButton[3:2] = 2'b00;
    wait_strobe(4'b1100, 1'b0, 30, lat);
    chk("b23_lat", lat, LAT);
    chk("b23_vec", opPressed, 4'b1100);
    repeat (5) tick();
    ipButton[3:2] = 2'b11;
    wait_strobe(4'b1100, 1'b1, 30, lat);
    chk("b23_rel_vec", opReleased, 4'b1100);
    repeat (5) tick();

    // Pin held low through a reset: no strobe on entry/exit, new press afterwards
    p0 = dut_prs_cnt[0];
    ipButton[0] = 1'b0;
    repeat (5) tick();
    ipReset = 1'b1;
    repeat (3) tick();
    ipReset = 1'b0;
    chk("rst_no_strobe", dut_prs_cnt[0] - p0, 0);
    wait_strobe(4'b0001, 1'b0, 30, lat);
    chk("rst_hold_lat", lat, LAT);
    ipButton[0] = 1'b1;
    wait_strobe(4'b0001, 1'b1, 30, lat);
    repeat (5) tick();

    // Reset pulse during PRESS_WAIT on bit 1 restarts the count
    ipButton[1] = 1'b0;
    repeat (6) tick();
    ipReset = 1'b1;
    tick();
    ipReset = 1'b0;
    wait_strobe(4'b0010, 1'b0, 30, lat);
    chk("rst_pw_lat", lat, LAT);
    ipButton[1] = 1'b1;
    wait_strobe(4'b0010, 1'b1, 30, lat);
    repeat (5) tick();

    // Long hold on bit 0: repeat strobes only when the feature is built in
    ipButton[0] = 1'b0;
    wait_strobe(4'b0001, 1'b0, 30, lat);
    chk("hold_press_lat", lat, LAT);
    nrep = 0; first = -1; second = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (opPressed[0]) begin
        nrep++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
`ifdef BUTTON_REPEAT_EN
    chk("rep_first", first, RDLY);
    chk("rep_second", second, RDLY + RPER);
    chk("rep_count", nrep, 11);
`else
    chk("rep_none", nrep, 0);
`endif
    p0 = dut_prs_cnt[0];
    r0 = dut_rel_cnt[0];
    ipButton[0] = 1'b1;
    repeat (20) tick();
    chk("rep_stop", dut_prs_cnt[0] - p0, 0);
    chk("rep_rel_once", dut_rel_cnt[0] - r0, 1);

    // Random phase: independent per-bit hold lengths, occasional reset pulses
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 14);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          ipButton[i] = ~ipButton[i];
          hold[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 80) : $urandom_range(1, 14);
        end else begin
          hold[i]--;
        end
      end
      if (ipReset) ipReset = 1'b0;
      else if ($urandom_range(0, 399) == 0) ipReset = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
